// File: rtl/multicycle_main_fsm_pkg.sv
// riscv_ctrl_pkg: opcodes, control encodings, FSM state type and decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. ILLEGAL_TRAP_EN adds the Illegal bit to the control word.
package riscv_ctrl_pkg;

   // RV32 major opcodes (instruction[6:0])
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BRCMP = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_PASSB = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   typedef enum logic [4:0] {
      S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_JALRADR, S_JUMP, S_BRANCH, S_LUI, S_AUIPC, S_ALUWB,
      S_ERROR, S_TRAP
   } state_e;

   // Moore part of the control word; registered in the FSM
   typedef struct packed {
      logic       mem_req;
      logic       adr_src;
      logic       pc_update;
      logic       branch;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       error;
`ifdef ILLEGAL_TRAP_EN
      logic       illegal;
`endif
   } ctrl_t;

   function automatic imm_src_e imm_decode(input logic [6:0] opc);
      case (opc)
         OPC_STORE:          return IMM_S;
         OPC_BRANCH:         return IMM_B;
         OPC_JAL:            return IMM_J;
         OPC_LUI, OPC_AUIPC: return IMM_U;
         default:            return IMM_I;  // load, JALR, OP-IMM and unknown opcodes
      endcase
   endfunction

   // States that wait on MemReady with MemReq raised
   function automatic logic is_wait(input state_e s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
         S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
         S_MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
         S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; c.instr_done = 1'b1; end
         S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
         S_EXECR:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_FUNCT; end
         S_EXECI:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
         S_JALRADR:  begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
         S_JUMP:     begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_update = 1'b1; end
         S_BRANCH:   begin
            c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_BRCMP;
            c.branch = 1'b1; c.instr_done = 1'b1;
         end
         S_LUI:      begin c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_PASSB; end
         S_AUIPC:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
         S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.instr_done = 1'b1; end
         S_ERROR:    c.error = 1'b1;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:     c.illegal = 1'b1;
`endif
         default:    ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: opcode/memory handshake inputs and control outputs of the main FSM.
// Latency: n/a (wires only); master = control FSM, slave = datapath/memory side.
// Backpressure: MemReq/MemReady handshake. ILLEGAL_TRAP_EN adds the Illegal signal.
interface multicycle_main_fsm_if #(
   parameter int IMM_W = 3
);
   logic [6:0]       opcode;
   logic             MemReady;
   logic             MemReq;
   logic             AdrSrc;
   logic             IRWrite;
   logic             PCUpdate;
   logic             Branch;
   logic             MemWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [IMM_W-1:0] ImmSrc;
   logic             InstrDone;
   logic             Error;
`ifdef ILLEGAL_TRAP_EN
   logic             Illegal;
`endif

   modport master (
      input  opcode, MemReady,
`ifdef ILLEGAL_TRAP_EN
      output Illegal,
`endif
      output MemReq, AdrSrc, IRWrite, PCUpdate, Branch, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, InstrDone, Error
   );

   modport slave (
      output opcode, MemReady,
`ifdef ILLEGAL_TRAP_EN
      input  Illegal,
`endif
      input  MemReq, AdrSrc, IRWrite, PCUpdate, Branch, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, InstrDone, Error
   );
endinterface

// File: rtl/multicycle_main_fsm_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits for MemReady; MEM_TIMEOUT=0 never expires.
// Latency: expired_o is combinational, high in the waiting cycle that brings the count to MEM_TIMEOUT.
// Backpressure: none; clr_i takes priority over en_i.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear on entry to a wait state, count each cycle spent waiting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CNT_W'(1);
   end

   // Wait counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // LAST waits already counted plus this one reaches the limit
   assign expired_o = (MEM_TIMEOUT != 0) && en_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: Moore control FSM sequencing fetch/decode/execute/memory/writeback; ILLEGAL_TRAP_EN traps unknown opcodes.
// Latency: Moore controls registered from next state; IRWrite, fetch PCUpdate, store InstrDone and ImmSrc are combinational.
// Backpressure: memory states hold MemReq/address controls until MemReady; MEM_TIMEOUT waiting cycles lead to sticky ERROR.
module multicycle_main_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int IMM_W       = 3
) (
   input logic                   clk,
   input logic                   rst_n,
   multicycle_main_fsm_if.master bus
);
   state_e     state_q, state_d;
   ctrl_t      ctrl_q;
   logic       tmr_clr, tmr_en, tmr_expired;
   logic       fetch_rdy;
   logic [2:0] imm_raw;

   assign tmr_en  = is_wait(state_q) && !bus.MemReady;
   assign tmr_clr = is_wait(state_d) && (state_d != state_q);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // Next-state selection: memory states wait on MemReady, DECODE dispatches on opcode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_START:  state_d = S_FETCH;
         S_FETCH: begin
            if (bus.MemReady)     state_d = S_DECODE;
            else if (tmr_expired) state_d = S_ERROR;
         end
         S_DECODE: begin
            case (bus.opcode)
               OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
               OPC_OP:              state_d = S_EXECR;
               OPC_OP_IMM:          state_d = S_EXECI;
               OPC_JAL:             state_d = S_JUMP;
               OPC_BRANCH:          state_d = S_BRANCH;
               OPC_JALR:            state_d = S_JALRADR;
               OPC_LUI:             state_d = S_LUI;
               OPC_AUIPC:           state_d = S_AUIPC;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  state_d = S_FETCH;  // unknown opcode retires silently as a NOP
`endif
               end
            endcase
         end
         S_MEMADR:  state_d = (bus.opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (bus.MemReady)     state_d = S_MEMWB;
            else if (tmr_expired) state_d = S_ERROR;
         end
         S_MEMWRITE: begin
            if (bus.MemReady)     state_d = S_FETCH;
            else if (tmr_expired) state_d = S_ERROR;
         end
         S_MEMWB, S_BRANCH, S_ALUWB:               state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JUMP, S_LUI, S_AUIPC: state_d = S_ALUWB;
         S_JALRADR:                                state_d = S_JUMP;
         default:                                  state_d = state_q;  // ERROR/TRAP wait for reset
      endcase
   end

   // State and registered Moore controls, precomputed from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_START;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   assign fetch_rdy = (state_q == S_FETCH) && bus.MemReady;
   assign imm_raw   = imm_decode(bus.opcode);

   assign bus.MemReq    = ctrl_q.mem_req;
   assign bus.AdrSrc    = ctrl_q.adr_src;
   assign bus.IRWrite   = fetch_rdy;
   assign bus.PCUpdate  = ctrl_q.pc_update | fetch_rdy;
   assign bus.Branch    = ctrl_q.branch;
   assign bus.MemWrite  = ctrl_q.mem_write;
   assign bus.RegWrite  = ctrl_q.reg_write;
   assign bus.ResultSrc = ctrl_q.result_src;
   assign bus.ALUSrcA   = ctrl_q.alu_src_a;
   assign bus.ALUSrcB   = ctrl_q.alu_src_b;
   assign bus.ALUOp     = ctrl_q.alu_op;
   assign bus.InstrDone = ctrl_q.instr_done | ((state_q == S_MEMWRITE) && bus.MemReady);
   assign bus.Error     = ctrl_q.error;
`ifdef ILLEGAL_TRAP_EN
   assign bus.Illegal   = ctrl_q.illegal;
`endif
   // Reset, error and trap states drive every output low, ImmSrc included
   assign bus.ImmSrc = (state_q == S_START || state_q == S_ERROR || state_q == S_TRAP)
                       ? '0 : IMM_W'(imm_raw);
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: randomized instruction stream checked cycle by cycle against a per-instruction trace model.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: MemReady waits randomized, including timeout-boundary lengths.
module tb_multicycle_main_fsm;
   localparam int TO = 15;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [2:0] imm;
      logic       req, adr, irw, pcu, br, mwr, rw;
      logic [1:0] rs, sa, sb, aop;
      logic       done, err, ill;
   } obs_t;

   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_cyc = 0;
   int   n_done = 0;
   obs_t ZERO = '0;
   logic [6:0] ops [12] = '{LOAD, STORE, BRANCH, OPIMM, OP, JAL, JALR, LUI, AUIPC,
                            7'h00, 7'h7f, 7'h0f};

   multicycle_main_fsm_if #(.IMM_W(3)) bus ();

   multicycle_main_fsm #(.MEM_TIMEOUT(TO), .IMM_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic obs_t obs();
      obs_t o;
      o.imm = bus.ImmSrc;  o.req = bus.MemReq;    o.adr = bus.AdrSrc;
      o.irw = bus.IRWrite; o.pcu = bus.PCUpdate;  o.br  = bus.Branch;
      o.mwr = bus.MemWrite; o.rw = bus.RegWrite;  o.rs  = bus.ResultSrc;
      o.sa  = bus.ALUSrcA; o.sb  = bus.ALUSrcB;   o.aop = bus.ALUOp;
      o.done = bus.InstrDone; o.err = bus.Error;
`ifdef ILLEGAL_TRAP_EN
      o.ill = bus.Illegal;
`else
      o.ill = 1'b0;
`endif
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return TO - 1;
      if (r == 1) return TO;
      return r % 4;
   endfunction

   // Immediate format expected for each opcode
   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         STORE:        return 3'd1;
         BRANCH:       return 3'd2;
         JAL:          return 3'd3;
         LUI, AUIPC:   return 3'd4;
         default:      return 3'd0;
      endcase
   endfunction

   function automatic logic known(input logic [6:0] op);
      return op inside {LOAD, STORE, BRANCH, OPIMM, OP, JAL, JALR, LUI, AUIPC};
   endfunction

   function automatic obs_t mk(input logic [2:0] imm, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] aop, input logic [1:0] rs, input logic pcu,
                               input logic br, input logic rw, input logic done);
      obs_t e;
      e = '0;
      e.imm = imm; e.sa = sa; e.sb = sb; e.aop = aop; e.rs = rs;
      e.pcu = pcu; e.br = br; e.rw = rw; e.done = done;
      return e;
   endfunction

   // One clock cycle: drive MemReady, compare all outputs, advance to next negedge
   task automatic cyc(input logic rdy, input obs_t e, input string tag);
      bus.MemReady = rdy;
      #1;
      chk(tag, 32'(obs()), 32'(e));
      if (bus.InstrDone) n_done++;
      n_cyc++;
      @(negedge clk);
   endtask

   // w low MemReady cycles then one ready cycle; died when the wait hits the timeout
   task automatic mem_phase(input obs_t w, input obs_t r, input int nw, input string tag,
                            output bit died);
      died = 1'b0;
      for (int i = 0; i < nw; i++) begin
         cyc(1'b0, w, tag);
         if (TO != 0 && i + 1 == TO) begin
            died = 1'b1;
            return;
         end
      end
      cyc(1'b1, r, tag);
   endtask

   task automatic err_phase();
      obs_t e;
      e = '0; e.err = 1'b1;
      repeat (3) cyc(rb(), e, "error");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_async_req", 32'(bus.MemReq), 32'd0);
      @(negedge clk);
      chk("rst_state", 32'(obs()), 32'(ZERO));
      rst_n = 1'b1;
      cyc(rb(), ZERO, "start");
   endtask

   // Whole instruction from FETCH until the cycle before the next FETCH
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, output bit died);
      obs_t w, r;
      logic [2:0] im;
      int d0;
      d0 = n_done;
      died = 1'b0;
      bus.opcode = op;
      im = imm_of(op);
      w = mk(im, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      w.req = 1'b1;
      r = w; r.irw = 1'b1; r.pcu = 1'b1;
      mem_phase(w, r, fw, "fetch", died);
      if (died) begin err_phase(); return; end
      cyc(rb(), mk(im, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0), "decode");
      case (op)
         LOAD, STORE: begin
            cyc(rb(), mk(im, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0), "memadr");
            w = mk(im, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
            w.req = 1'b1; w.adr = 1'b1; w.mwr = (op == STORE);
            r = w; r.done = (op == STORE);
            mem_phase(w, r, mw, "mem", died);
            if (died) begin err_phase(); return; end
            if (op == LOAD) cyc(rb(), mk(im, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 1), "memwb");
         end
         OP:     cyc(rb(), mk(im, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0), "execr");
         OPIMM:  cyc(rb(), mk(im, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0), "execi");
         BRANCH: cyc(rb(), mk(im, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1, 0, 1), "branch");
         LUI:    cyc(rb(), mk(im, 2'b00, 2'b01, 2'b11, 2'b00, 0, 0, 0, 0), "lui");
         AUIPC:  cyc(rb(), mk(im, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0), "auipc");
         JAL, JALR: begin
            if (op == JALR) cyc(rb(), mk(im, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0), "jalradr");
            cyc(rb(), mk(im, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0), "jump");
         end
         default: begin
`ifdef ILLEGAL_TRAP_EN
            w = '0; w.ill = 1'b1;
            repeat (3) cyc(rb(), w, "trap");
            died = 1'b1;
            return;
`endif
         end
      endcase
      if (op inside {OP, OPIMM, LUI, AUIPC, JAL, JALR})
         cyc(rb(), mk(im, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1), "aluwb");
      chk("done_cnt", 32'(n_done - d0), known(op) ? 32'd1 : 32'd0);
   endtask

   initial begin
      bit   died;
      int   c0;
      obs_t w;
      rst_n = 1'b0;
      bus.MemReady = 1'b0;
      bus.opcode = 7'h00;
      repeat (2) @(negedge clk);
      chk("reset", 32'(obs()), 32'(ZERO));
      rst_n = 1'b1;
      cyc(1'b1, ZERO, "start");

      c0 = n_cyc; run_instr(OP, 0, 0, died);   chk("r_cycles", 32'(n_cyc - c0), 32'd4);
      c0 = n_cyc; run_instr(LOAD, 0, 3, died); chk("lw_cycles", 32'(n_cyc - c0), 32'd8);
      run_instr(JALR, 1, 0, died);
      run_instr(LUI, 0, 0, died);
      run_instr(STORE, 2, 2, died);
      run_instr(OPIMM, TO - 1, 0, died);
      chk("wait_boundary_ok", 32'(died), 32'd0);
      run_instr(7'h00, 0, 0, died);
      if (died) do_reset();

      run_instr(OP, TO, 0, died);
      chk("fetch_timeout", 32'(died), 32'd1);
      do_reset();
      run_instr(LOAD, 0, TO, died);
      chk("read_timeout", 32'(died), 32'd1);
      do_reset();

      // Reset asserted in the middle of a fetch wait
      bus.opcode = OP;
      w = mk(3'd0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0);
      w.req = 1'b1;
      cyc(1'b0, w, "fetch_pre_rst");
      cyc(1'b0, w, "fetch_pre_rst");
      do_reset();

      for (int n = 0; n < 80; n++) begin
         run_instr(ops[$urandom_range(0, 11)], pick_wait(), pick_wait(), died);
         if (died) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Next-generation main control unit for the multi-cycle RISC-V core. It replaces the single-cycle combinational opcode decoder with a Moore FSM.
- Sequences fetch / decode / execute / memory / writeback for every instruction.
- Waits on a variable-latency memory via a req/ready handshake.
- Extends coverage beyond the single-cycle set to JALR, LUI and AUIPC.

Parameters:
- MEM_TIMEOUT, 15, max cycles MemReq may wait for MemReady before Error; 0 disables the timeout.
- IMM_W, 3, ImmSrc width; widened to hold the U-type encoding.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from the instruction register
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access request
- AdrSrc  out  1  0 = PC, 1 = Result (data address)
- IRWrite  out  1  load instruction register
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  conditional PC write (gated by Zero externally)
- MemWrite  out  1  store strobe
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 R/I funct, 11 pass B
- ImmSrc  out  IMM_W  0 I, 1 S, 2 B, 3 J, 4 U
- InstrDone  out  1  one-cycle pulse when an instruction retires
- Error  out  1  sticky memory-timeout flag

Behaviour:
- Reset: asynchronous on rst_n low. State becomes START, wait counter is 0, Error is 0, and all outputs are 0. START outputs all zeros and goes to FETCH next cycle.
- ImmSrc is decoded combinationally from opcode in every state:
  - 0000011 → I; 0100011 → S; 1100011 → B; 1101111 → J; 0110111 / 0010111 → U; 1100111 → I; 0010011 → I.
  - Anything else → 0.
- All other outputs are Moore from state, except IRWrite, PCUpdate-in-FETCH, and the memory strobes, which are qualified by MemReady as stated below.
- State actions and transitions:
  - FETCH: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. Hold until MemReady. In the MemReady cycle, IRWrite=1 and PCUpdate=1, then go to DECODE.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch/JAL target into ALUOut). Next state by opcode:
    - load/store → MEMADR
    - R (0110011) → EXECR
    - I-ALU → EXECI
    - JAL → JUMP
    - B → BRANCH
    - JALR → JALRADR
    - LUI → LUI
    - AUIPC → AUIPC
    - other → FETCH, with InstrDone=0
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00. Go to MEMREAD if opcode is load, else MEMWRITE.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. On MemReady go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: MemReq=1, AdrSrc=1, ResultSrc=00. MemWrite=1 for the whole wait. On MemReady go to FETCH.
  - EXECR: SrcA=10, SrcB=00, ALUOp=10, then ALUWB.
  - EXECI: SrcA=10, SrcB=01, ALUOp=10, then ALUWB.
  - JALRADR: SrcA=10, SrcB=01, ALUOp=00, then JUMP.
  - JUMP: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB (rd = OldPC+4).
  - BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
  - LUI: SrcB=01, ALUOp=11, then ALUWB.
  - AUIPC: SrcA=01, SrcB=01, ALUOp=00, then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- InstrDone: asserted in the last cycle before returning to FETCH: MEMWB, ALUWB, BRANCH, and MEMWRITE's MemReady cycle.
- Handshake:
  - MemReq and its address controls stay stable until MemReady is sampled high.
  - MemReady while MemReq=0 is ignored.
  - Zero-wait memory (MemReady already high) completes in one cycle.
- Timeout:
  - The counter clears on entry to FETCH, MEMREAD and MEMWRITE, and increments each waiting cycle.
  - If it reaches MEM_TIMEOUT without MemReady, go to ERROR: all outputs 0 and Error=1. ERROR is exited only by reset.
- Reset mid-access drops MemReq immediately (asynchronous).

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- When defined:
  - An unknown opcode in DECODE goes to ERROR-like state TRAP.
  - An extra output, Illegal, is 1 sticky until reset; all other outputs are 0 in TRAP.
- When undefined: an unknown opcode goes to FETCH as a NOP, and no Illegal port exists.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (LOAD, STORE, BRANCH, OP_IMM, OP, JAL, JALR, LUI, AUIPC)
  - ImmSrc, ALUOp, ResultSrc and ALUSrc encodings
  - the state enum typedef
- One sub-module: mem_wait_timer (counter plus timeout compare, clear/enable inputs, expired output).

Test Plan:
- R-type add, MemReady tied 1 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 in cycle 4, InstrDone pulses once, 4 cycles total.
- lw with MemReady low for 3 cycles in MEMREAD → MemReq held 4 cycles with AdrSrc=1 stable, then MEMWB with ResultSrc=01. Total 8 cycles.
- JALR (1100111) → DECODE, JALRADR, JUMP (PCUpdate=1, ResultSrc=00), then ALUWB with RegWrite=1. ImmSrc=0 throughout.
- LUI → ImmSrc=4, ALUOp=11, SrcB=01 in LUI state, then ALUWB write.
- MEM_TIMEOUT=15, MemReady stuck 0 in FETCH → Error=1 after 15 wait cycles and all outputs 0. Reset clears Error and starts START→FETCH.
- Opcode 0000000: macro off → back to FETCH with no writes. Macro on → Illegal=1, MemReq=0 until rst_n low.
